cluster_mem_arb: RTL and testbench

- Parametrised N-to-1 memory request arbiter with tag-routed response demux, used between per-core memory ports and the cluster memory port when the L2 is disabled.
- Extends the plain arbiter with selectable round-robin or fixed-priority arbitration and per-requester outstanding-read credit limits.
- Adds registered request and response stages and a busy status output.

---
 rtl/cluster_mem_arb.sv | 274 +++++++++++++++++++++++++++
 tb/tb_cluster_mem_arb.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_mem_arb.sv
// cluster_mem_arb
// N-to-1 memory request arbiter with tag-routed response demux. Sits between
// the per-core memory ports and the cluster memory port when the L2 is off.
//
// Request side: each requester presents valid/rw/byteen/addr/data/tag. A single
// output register is loaded whenever it is empty or being drained. On a load,
// exactly one eligible requester is granted, using round-robin (ARB_MODE = 0)
// or lowest-index-first (ARB_MODE = 1). A read is eligible only while its
// requester has fewer than MAX_PENDING reads outstanding. Writes never use credit.
// The requester index is inserted into the outgoing tag at bit TAG_SEL_IDX.
//
// Response side: the requester index is pulled out of rsp_tag_in and stripped
// from the tag. The response then enters a 1-entry register. Data and tag are
// broadcast, and only the owning requester sees valid.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   req_*_in  / req_ready_in       per-requester request channel
//   req_*_out / req_ready_out      merged request channel to memory
//   rsp_*_in  / rsp_ready_in       response channel from memory
//   rsp_*_out / rsp_ready_out      per-requester response channel
//   busy                           reads outstanding or any stage occupied
module cluster_mem_arb #(
  parameter int unsigned NUM_REQS      = 4,
  parameter int unsigned DATA_WIDTH    = 512,
  parameter int unsigned ADDR_WIDTH    = 26,
  parameter int unsigned TAG_IN_WIDTH  = 8,
  parameter int unsigned TAG_SEL_IDX   = 1,
  parameter int unsigned ARB_MODE      = 0,
  parameter int unsigned MAX_PENDING   = 4,
  localparam int unsigned LOG_NUM_REQS  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 0,
  localparam int unsigned TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_NUM_REQS,
  localparam int unsigned BYTEEN_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                                       clk,
  input  logic                                       reset,
  // requester-side request channel
  input  logic [NUM_REQS-1:0]                        req_valid_in,
  input  logic [NUM_REQS-1:0]                        req_rw_in,
  input  logic [NUM_REQS-1:0][BYTEEN_WIDTH-1:0]      req_byteen_in,
  input  logic [NUM_REQS-1:0][ADDR_WIDTH-1:0]        req_addr_in,
  input  logic [NUM_REQS-1:0][DATA_WIDTH-1:0]        req_data_in,
  input  logic [NUM_REQS-1:0][TAG_IN_WIDTH-1:0]      req_tag_in,
  output logic [NUM_REQS-1:0]                        req_ready_in,
  // memory-side request channel
  output logic                                       req_valid_out,
  output logic                                       req_rw_out,
  output logic [BYTEEN_WIDTH-1:0]                    req_byteen_out,
  output logic [ADDR_WIDTH-1:0]                      req_addr_out,
  output logic [DATA_WIDTH-1:0]                      req_data_out,
  output logic [TAG_OUT_WIDTH-1:0]                   req_tag_out,
  input  logic                                       req_ready_out,
  // memory-side response channel
  input  logic                                       rsp_valid_in,
  input  logic [DATA_WIDTH-1:0]                      rsp_data_in,
  input  logic [TAG_OUT_WIDTH-1:0]                   rsp_tag_in,
  output logic                                       rsp_ready_in,
  // requester-side response channel
  output logic [NUM_REQS-1:0]                        rsp_valid_out,
  output logic [NUM_REQS-1:0][DATA_WIDTH-1:0]        rsp_data_out,
  output logic [NUM_REQS-1:0][TAG_IN_WIDTH-1:0]      rsp_tag_out,
  input  logic [NUM_REQS-1:0]                        rsp_ready_out,
  // status
  output logic                                       busy
);

  localparam int unsigned IDX_W = (LOG_NUM_REQS > 0) ? LOG_NUM_REQS : 1;
  localparam int unsigned CNT_W = $clog2(MAX_PENDING + 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                                req_buf_valid_q;
  logic                                req_rw_q;
  logic [BYTEEN_WIDTH-1:0]             req_byteen_q;
  logic [ADDR_WIDTH-1:0]               req_addr_q;
  logic [DATA_WIDTH-1:0]               req_data_q;
  logic [TAG_OUT_WIDTH-1:0]            req_tag_q;

  logic                                rsp_buf_valid_q;
  logic [IDX_W-1:0]                    rsp_idx_q;
  logic [DATA_WIDTH-1:0]               rsp_data_q;
  logic [TAG_IN_WIDTH-1:0]             rsp_tag_q;

  logic [NUM_REQS-1:0][CNT_W-1:0]      cnt_q;
  logic [NUM_REQS-1:0][CNT_W-1:0]      cnt_d;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [NUM_REQS-1:0]                 eligible;
  logic [IDX_W-1:0]                    grant_idx;
  logic                                grant_any;
  logic                                load_en;
  logic [TAG_OUT_WIDTH-1:0]            tag_ins;
  logic [IDX_W-1:0]                    rsp_idx;
  logic [TAG_IN_WIDTH-1:0]             rsp_tag_strip;
  logic [NUM_REQS-1:0]                 rsp_fire;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < int'(NUM_REQS); i++) begin
      eligible[i] = req_valid_in[i] & (req_rw_in[i] | (cnt_q[i] < CNT_W'(MAX_PENDING)));
    end
  end

  assign load_en   = ~req_buf_valid_q | req_ready_out;
  assign grant_any = |eligible;

  generate
    if (NUM_REQS == 1) begin : g_single
      // Single requester: no arbitration state, tag passes through untouched.
      assign grant_idx     = '0;
      assign tag_ins       = req_tag_in[0];
      assign rsp_idx       = '0;
      assign rsp_tag_strip = rsp_tag_in;
    end else begin : g_multi
      localparam logic [TAG_OUT_WIDTH-1:0] LowMask =
        TAG_OUT_WIDTH'((64'd1 << TAG_SEL_IDX) - 64'd1);

      logic [TAG_OUT_WIDTH-1:0] tag_ext;
      assign tag_ext = TAG_OUT_WIDTH'(req_tag_in[grant_idx]);

      // Upper tag bits shift up to open a LOG_NUM_REQS-wide hole at TAG_SEL_IDX.
      assign tag_ins = ((tag_ext & ~LowMask) << LOG_NUM_REQS)
                     | (TAG_OUT_WIDTH'(grant_idx) << TAG_SEL_IDX)
                     | (tag_ext & LowMask);

      assign rsp_idx       = rsp_tag_in[TAG_SEL_IDX +: IDX_W];
      assign rsp_tag_strip = TAG_IN_WIDTH'(((rsp_tag_in >> LOG_NUM_REQS) & ~LowMask)
                                           | (rsp_tag_in & LowMask));

      if (ARB_MODE == 0) begin : g_rr
        logic [IDX_W-1:0] ptr_q;

        // First eligible requester at or after the pointer, wrapping modulo NUM_REQS.
        always_comb begin
          int   sum;
          logic found;
          sum       = 0;
          found     = 1'b0;
          grant_idx = ptr_q;
          for (int k = 0; k < int'(NUM_REQS); k++) begin
            sum = int'(ptr_q) + k;
            if (sum >= int'(NUM_REQS)) begin
              sum = sum - int'(NUM_REQS);
            end
            if (!found && eligible[IDX_W'(sum)]) begin
              grant_idx = IDX_W'(sum);
              found     = 1'b1;
            end
          end
        end

        always_ff @(posedge clk) begin
          if (reset) begin
            ptr_q <= '0;
          end else if (load_en && grant_any) begin
            if (grant_idx == IDX_W'(NUM_REQS - 1)) begin
              ptr_q <= '0;
            end else begin
              ptr_q <= grant_idx + IDX_W'(1);
            end
          end
        end
      end else begin : g_fp
        // Scan from the top so the lowest eligible index is written last.
        always_comb begin
          grant_idx = '0;
          for (int k = int'(NUM_REQS) - 1; k >= 0; k--) begin
            if (eligible[k]) begin
              grant_idx = IDX_W'(k);
            end
          end
        end
      end
    end
  endgenerate

  assign req_ready_in = (load_en && grant_any) ? (NUM_REQS'(1) << grant_idx) : '0;

  // ---------------------------------------------------------------------------
  // Request stage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      req_buf_valid_q <= 1'b0;
    end else if (load_en) begin
      req_buf_valid_q <= grant_any;
      if (grant_any) begin
        req_rw_q     <= req_rw_in[grant_idx];
        req_byteen_q <= req_byteen_in[grant_idx];
        req_addr_q   <= req_addr_in[grant_idx];
        req_data_q   <= req_data_in[grant_idx];
        req_tag_q    <= tag_ins;
      end
    end
  end

  assign req_valid_out  = req_buf_valid_q;
  assign req_rw_out     = req_rw_q;
  assign req_byteen_out = req_byteen_q;
  assign req_addr_out   = req_addr_q;
  assign req_data_out   = req_data_q;
  assign req_tag_out    = req_tag_q;

  // ---------------------------------------------------------------------------
  // Response stage
  // ---------------------------------------------------------------------------
  assign rsp_ready_in = ~rsp_buf_valid_q | rsp_ready_out[rsp_idx_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_buf_valid_q <= 1'b0;
    end else if (rsp_ready_in) begin
      rsp_buf_valid_q <= rsp_valid_in;
      if (rsp_valid_in) begin
        rsp_idx_q  <= rsp_idx;
        rsp_data_q <= rsp_data_in;
        rsp_tag_q  <= rsp_tag_strip;
      end
    end
  end

  assign rsp_valid_out = rsp_buf_valid_q ? (NUM_REQS'(1) << rsp_idx_q) : '0;
  assign rsp_data_out  = {NUM_REQS{rsp_data_q}};
  assign rsp_tag_out   = {NUM_REQS{rsp_tag_q}};
  assign rsp_fire      = rsp_valid_out & rsp_ready_out;

  // ---------------------------------------------------------------------------
  // Outstanding-read credit counters
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < int'(NUM_REQS); i++) begin
      logic inc;
      logic dec;
      inc = req_ready_in[i] & ~req_rw_in[i];
      // A stray response never drags the counter below zero.
      dec = rsp_fire[i] & (cnt_q[i] != '0);
      if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec && !inc) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (|cnt_q) | req_buf_valid_q | rsp_buf_valid_q;

  // ---------------------------------------------------------------------------
  // Simulation checks
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < int'(NUM_REQS); gi++) begin : g_chk_credit
      a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        rsp_fire[gi] |-> (cnt_q[gi] != '0));
    end
    // Out-of-range indices can only be encoded when NUM_REQS is not a power of two.
    if ((1 << LOG_NUM_REQS) != NUM_REQS) begin : g_chk_idx
      a_idx_range: assert property (@(posedge clk) disable iff (reset)
        (rsp_valid_in && rsp_ready_in) |-> (int'(rsp_idx) < int'(NUM_REQS)));
    end
  endgenerate

endmodule

// File: tb/tb_cluster_mem_arb.sv
// Bench for cluster_mem_arb. Two instances are used: round-robin with
// MAX_PENDING = 2, and fixed priority. Expected request and response beats are
// queued by the stimulus. Negedge monitors pop and compare on every handshake.
module tb_cluster_mem_arb;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int TIW = 8;
  localparam int TOW = 10;

  typedef struct packed {
    logic           rw;
    logic [3:0]     be;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
    logic [TOW-1:0] tag;
  } req_t;

  typedef struct packed {
    logic [N-1:0]   vld;
    logic [1:0]     lane;
    logic [TIW-1:0] tag;
    logic [DW-1:0]  data;
  } rsp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Shared request payloads.
  logic [N-1:0][3:0]     be_v;
  logic [N-1:0][AW-1:0]  addr_v;
  logic [N-1:0][DW-1:0]  data_v;
  logic [N-1:0][TIW-1:0] tag_v;

  // Round-robin instance.
  logic [N-1:0]          rr_valid, rr_rw, rr_ready_in;
  logic                  rr_vout, rr_rw_out, rr_ready_out;
  logic [3:0]            rr_be_out;
  logic [AW-1:0]         rr_addr_out;
  logic [DW-1:0]         rr_data_out;
  logic [TOW-1:0]        rr_tag_out;
  logic                  rsp_valid_in, rr_rsp_ready_in;
  logic [DW-1:0]         rsp_data_in;
  logic [TOW-1:0]        rsp_tag_in;
  logic [N-1:0]          rr_rsp_valid_out, rr_rsp_ready_out;
  logic [N-1:0][DW-1:0]  rr_rsp_data_out;
  logic [N-1:0][TIW-1:0] rr_rsp_tag_out;
  logic                  rr_busy;

  // Fixed-priority instance.
  logic [N-1:0]          fp_valid, fp_rw, fp_ready_in;
  logic                  fp_vout, fp_rw_out, fp_ready_out;
  logic [3:0]            fp_be_out;
  logic [AW-1:0]         fp_addr_out;
  logic [DW-1:0]         fp_data_out;
  logic [TOW-1:0]        fp_tag_out;
  logic                  fp_rsp_valid_in, fp_rsp_ready_in;
  logic [DW-1:0]         fp_rsp_data_in;
  logic [TOW-1:0]        fp_rsp_tag_in;
  logic [N-1:0]          fp_rsp_valid_out, fp_rsp_ready_out;
  logic [N-1:0][DW-1:0]  fp_rsp_data_out;
  logic [N-1:0][TIW-1:0] fp_rsp_tag_out;
  logic                  fp_busy;

  cluster_mem_arb #(
    .NUM_REQS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_IN_WIDTH(TIW),
    .TAG_SEL_IDX(1), .ARB_MODE(0), .MAX_PENDING(2)
  ) u_rr (
    .clk(clk), .reset(reset),
    .req_valid_in(rr_valid), .req_rw_in(rr_rw), .req_byteen_in(be_v),
    .req_addr_in(addr_v), .req_data_in(data_v), .req_tag_in(tag_v),
    .req_ready_in(rr_ready_in),
    .req_valid_out(rr_vout), .req_rw_out(rr_rw_out), .req_byteen_out(rr_be_out),
    .req_addr_out(rr_addr_out), .req_data_out(rr_data_out), .req_tag_out(rr_tag_out),
    .req_ready_out(rr_ready_out),
    .rsp_valid_in(rsp_valid_in), .rsp_data_in(rsp_data_in), .rsp_tag_in(rsp_tag_in),
    .rsp_ready_in(rr_rsp_ready_in),
    .rsp_valid_out(rr_rsp_valid_out), .rsp_data_out(rr_rsp_data_out),
    .rsp_tag_out(rr_rsp_tag_out), .rsp_ready_out(rr_rsp_ready_out),
    .busy(rr_busy)
  );

  cluster_mem_arb #(
    .NUM_REQS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_IN_WIDTH(TIW),
    .TAG_SEL_IDX(1), .ARB_MODE(1), .MAX_PENDING(4)
  ) u_fp (
    .clk(clk), .reset(reset),
    .req_valid_in(fp_valid), .req_rw_in(fp_rw), .req_byteen_in(be_v),
    .req_addr_in(addr_v), .req_data_in(data_v), .req_tag_in(tag_v),
    .req_ready_in(fp_ready_in),
    .req_valid_out(fp_vout), .req_rw_out(fp_rw_out), .req_byteen_out(fp_be_out),
    .req_addr_out(fp_addr_out), .req_data_out(fp_data_out), .req_tag_out(fp_tag_out),
    .req_ready_out(fp_ready_out),
    .rsp_valid_in(fp_rsp_valid_in), .rsp_data_in(fp_rsp_data_in),
    .rsp_tag_in(fp_rsp_tag_in), .rsp_ready_in(fp_rsp_ready_in),
    .rsp_valid_out(fp_rsp_valid_out), .rsp_data_out(fp_rsp_data_out),
    .rsp_tag_out(fp_rsp_tag_out), .rsp_ready_out(fp_rsp_ready_out),
    .busy(fp_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  req_t rq[$];
  req_t fq[$];
  rsp_t sq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Requester index inserted at bit 1 of the tag.
  function automatic logic [TOW-1:0] ins(input logic [TIW-1:0] t, input logic [1:0] i);
    return {t[7:1], i, t[0]};
  endfunction

  function automatic req_t exp_req(input logic [1:0] i, input logic rw);
    req_t r;
    r.rw   = rw;
    r.be   = be_v[i];
    r.addr = addr_v[i];
    r.data = data_v[i];
    r.tag  = ins(tag_v[i], i);
    return r;
  endfunction

  function automatic rsp_t exp_rsp(input logic [1:0] i, input logic [TIW-1:0] t,
                                   input logic [DW-1:0] d);
    rsp_t r;
    r.vld  = 4'b0001 << i;
    r.lane = i;
    r.tag  = t;
    r.data = d;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic send_rsp(input logic [1:0] i, input logic [TIW-1:0] t, input logic [DW-1:0] d);
    rsp_valid_in = 1'b1;
    rsp_tag_in   = ins(t, i);
    rsp_data_in  = d;
  endtask

  // Monitors sample at the negedge, half a cycle from the active edge.
  always @(negedge clk) begin
    if (!reset && rr_vout && rr_ready_out) begin
      if (rq.size() == 0) begin
        chk("rr_req_unexpected", 64'(rr_tag_out), 64'hdead);
      end else begin
        req_t e;
        e = rq.pop_front();
        chk("rr_req_beat", 64'(req_t'({rr_rw_out, rr_be_out, rr_addr_out, rr_data_out,
                                        rr_tag_out})), 64'(e));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && fp_vout && fp_ready_out) begin
      if (fq.size() == 0) begin
        chk("fp_req_unexpected", 64'(fp_tag_out), 64'hdead);
      end else begin
        req_t e;
        e = fq.pop_front();
        chk("fp_req_beat", 64'(req_t'({fp_rw_out, fp_be_out, fp_addr_out, fp_data_out,
                                        fp_tag_out})), 64'(e));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && |(rr_rsp_valid_out & rr_rsp_ready_out)) begin
      if (sq.size() == 0) begin
        chk("rsp_unexpected", 64'(rr_rsp_valid_out), 64'hdead);
      end else begin
        rsp_t e;
        e = sq.pop_front();
        chk("rsp_beat", 64'(rsp_t'({rr_rsp_valid_out, e.lane, rr_rsp_tag_out[e.lane],
                                     rr_rsp_data_out[e.lane]})), 64'(e));
      end
    end
  end

  initial begin
    int fair [5];
    fair[0] = 0; fair[1] = 1; fair[2] = 2; fair[3] = 3; fair[4] = 0;

    reset            = 1'b1;
    rr_valid         = '0;
    rr_rw            = '0;
    rr_ready_out     = 1'b1;
    rsp_valid_in     = 1'b0;
    rsp_data_in      = '0;
    rsp_tag_in       = '0;
    rr_rsp_ready_out = 4'hF;
    fp_valid         = '0;
    fp_rw            = '0;
    fp_ready_out     = 1'b1;
    fp_rsp_valid_in  = 1'b0;
    fp_rsp_data_in   = '0;
    fp_rsp_tag_in    = '0;
    fp_rsp_ready_out = 4'hF;
    for (int i = 0; i < N; i++) begin
      be_v[i]   = 4'hF ^ 4'(i);
      addr_v[i] = 16'h1000 + 16'(i) * 16'h0111;
      data_v[i] = 32'hD000_0000 + 32'(i);
      tag_v[i]  = 8'h40 + 8'(i * 19);
    end

    repeat (2) tick();
    tick();
    reset = 1'b0;
    settle();
    chk("reset_req_valid", 64'(rr_vout), 64'd0);
    chk("reset_rsp_valid", 64'(rr_rsp_valid_out), 64'd0);
    chk("reset_busy", 64'(rr_busy), 64'd0);
    chk("reset_fp_valid", 64'(fp_vout), 64'd0);

    // Round-robin fairness: all four reading, grants 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      tick();
      rr_valid = 4'hF;
      settle();
      chk("rr_fair_grant", 64'(rr_ready_in), 64'(4'b0001 << fair[k]));
      rq.push_back(exp_req(2'(fair[k]), 1'b0));
    end
    tick();
    rr_valid = '0;
    settle();
    tick();
    settle();
    chk("busy_reads_out", 64'(rr_busy), 64'd1);

    // Response routing and response backpressure.
    tick();
    send_rsp(2'd3, 8'h5A, 32'hCAFE_0003);
    settle();
    chk("rsp_ready_empty", 64'(rr_rsp_ready_in), 64'd1);
    sq.push_back(exp_rsp(2'd3, 8'h5A, 32'hCAFE_0003));
    tick();
    send_rsp(2'd2, 8'h21, 32'hCAFE_0002);
    rr_rsp_ready_out = 4'b1011;
    settle();
    chk("rsp_ready_draining", 64'(rr_rsp_ready_in), 64'd1);
    sq.push_back(exp_rsp(2'd2, 8'h21, 32'hCAFE_0002));
    tick();
    send_rsp(2'd1, 8'h11, 32'hCAFE_0001);
    settle();
    for (int k = 0; k < 2; k++) begin
      chk("rsp_hold_valid", 64'(rr_rsp_valid_out), 64'(4'b0100));
      chk("rsp_hold_ready", 64'(rr_rsp_ready_in), 64'd0);
      if (k == 0) begin
        tick();
        settle();
      end
    end
    tick();
    rr_rsp_ready_out = 4'hF;
    settle();
    chk("rsp_release_ready", 64'(rr_rsp_ready_in), 64'd1);
    sq.push_back(exp_rsp(2'd1, 8'h11, 32'hCAFE_0001));
    tick();
    rsp_valid_in = 1'b0;
    settle();
    tick();
    settle();
    chk("busy_cnt0_left", 64'(rr_busy), 64'd1);

    // Credit limit: requester 0 already holds 2 reads.
    tick();
    rr_valid = 4'b0011;
    rr_rw    = 4'b0000;
    settle();
    chk("credit_other_granted", 64'(rr_ready_in), 64'(4'b0010));
    rq.push_back(exp_req(2'd1, 1'b0));
    tick();
    rr_valid = 4'b0001;
    settle();
    chk("credit_held", 64'(rr_ready_in), 64'd0);
    tick();
    send_rsp(2'd0, 8'h07, 32'hCAFE_0010);
    settle();
    chk("credit_held_rsp_in", 64'(rr_ready_in), 64'd0);
    sq.push_back(exp_rsp(2'd0, 8'h07, 32'hCAFE_0010));
    tick();
    send_rsp(2'd0, 8'h08, 32'hCAFE_0011);
    settle();
    chk("credit_held_rsp_out", 64'(rr_ready_in), 64'd0);
    sq.push_back(exp_rsp(2'd0, 8'h08, 32'hCAFE_0011));
    tick();
    rsp_valid_in = 1'b0;
    settle();
    chk("credit_released", 64'(rr_ready_in), 64'(4'b0001));
    rq.push_back(exp_req(2'd0, 1'b0));
    tick();
    settle();
    chk("credit_simultaneous", 64'(rr_ready_in), 64'(4'b0001));
    rq.push_back(exp_req(2'd0, 1'b0));
    tick();
    settle();
    chk("credit_full_again", 64'(rr_ready_in), 64'd0);
    tick();
    rr_rw = 4'b0001;
    settle();
    chk("write_bypass", 64'(rr_ready_in), 64'(4'b0001));
    rq.push_back(exp_req(2'd0, 1'b1));
    tick();
    rr_rw = 4'b0000;
    settle();
    chk("write_no_credit", 64'(rr_ready_in), 64'd0);
    tick();
    rr_valid = '0;
    settle();

    // Request backpressure: output register frozen for 3 cycles.
    tick();
    rr_valid = 4'b1100;
    rr_rw    = 4'b1100;
    settle();
    chk("bp_first_grant", 64'(rr_ready_in), 64'(4'b0100));
    rq.push_back(exp_req(2'd2, 1'b1));
    for (int k = 0; k < 3; k++) begin
      tick();
      rr_ready_out = 1'b0;
      settle();
      chk("bp_no_grant", 64'(rr_ready_in), 64'd0);
      chk("bp_fields_stable", {rr_vout, rr_rw_out, rr_be_out, rr_addr_out, rr_data_out,
                               rr_tag_out}, {1'b1, exp_req(2'd2, 1'b1)});
    end
    tick();
    rr_ready_out = 1'b1;
    settle();
    chk("bp_resume_grant", 64'(rr_ready_in), 64'(4'b1000));
    rq.push_back(exp_req(2'd3, 1'b1));
    tick();
    rr_valid = '0;
    rr_rw    = '0;
    settle();

    // Reset in the middle of a burst with a response in flight.
    tick();
    rr_valid = 4'hF;
    settle();
    chk("burst_grant1", 64'(rr_ready_in), 64'(4'b0010));
    rq.push_back(exp_req(2'd1, 1'b0));
    tick();
    send_rsp(2'd1, 8'h33, 32'hCAFE_0020);
    settle();
    chk("burst_grant2", 64'(rr_ready_in), 64'(4'b0100));
    tick();
    reset        = 1'b1;
    rsp_valid_in = 1'b0;
    settle();
    tick();
    reset    = 1'b0;
    rr_valid = '0;
    settle();
    chk("midreset_req_valid", 64'(rr_vout), 64'd0);
    chk("midreset_rsp_valid", 64'(rr_rsp_valid_out), 64'd0);
    chk("midreset_busy", 64'(rr_busy), 64'd0);
    tick();
    rr_valid = 4'b1000;
    settle();
    chk("post_reset_grant", 64'(rr_ready_in), 64'(4'b1000));
    rq.push_back(exp_req(2'd3, 1'b0));
    tick();
    rr_valid = '0;
    settle();
    tick();
    settle();
    chk("post_reset_busy", 64'(rr_busy), 64'd1);

    // Fixed priority: requesters 1 and 3 both valid, only 1 ever wins.
    for (int k = 0; k < 6; k++) begin
      tick();
      fp_valid = 4'b1010;
      fp_rw    = 4'b1010;
      settle();
      chk("fp_grant", 64'(fp_ready_in), 64'(4'b0010));
      fq.push_back(exp_req(2'd1, 1'b1));
    end
    tick();
    fp_valid = '0;
    settle();
    repeat (2) tick();
    settle();

    chk("rr_req_queue_drained", 64'(rq.size()), 64'd0);
    chk("fp_req_queue_drained", 64'(fq.size()), 64'd0);
    chk("rsp_queue_drained", 64'(sq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
